// File: rtl/stream_xbar_pkg.sv
// Shared types and width helpers for the round-robin stream crossbar.
package stream_xbar_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } xbar_state_e;

  function automatic int id_width(input int s_count);
    return (s_count > 1) ? $clog2(s_count) : 1;
  endfunction

  function automatic int dest_width(input int m_count);
    return (m_count > 1) ? $clog2(m_count) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester found searching from last_grant+1 with wrap.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_xbar_rr.sv
// Packet-locked round-robin stream crossbar, one arbiter/FSM per output.
// Define STREAM_XBAR_OUT_REG_EN to put a registered slice on every output.
module stream_xbar_rr
  import stream_xbar_pkg::*;
#(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int S_DATA_COUNT = 2,
  parameter  int M_DATA_COUNT = 3,
  localparam int T_ID___WIDTH = id_width(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o,
  output logic [M_DATA_COUNT-1:0]                   m_last_o,
  output logic [M_DATA_COUNT-1:0]                   m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                   m_ready_i
);

  localparam int W  = T_DATA_WIDTH;
  localparam int IW = T_ID___WIDTH;

  logic [M_DATA_COUNT-1:0]         busy;
  logic [M_DATA_COUNT-1:0]         slice_rdy;
  logic [M_DATA_COUNT-1:0][IW-1:0] grant;
  logic [S_DATA_COUNT-1:0]         held;

  // Inputs already locked by a busy output are hidden from idle arbiters.
  always_comb begin
    held = '0;
    for (int j = 0; j < M_DATA_COUNT; j++)
      if (busy[j]) held[grant[j]] = 1'b1;
  end

  always_comb begin
    s_ready_o = '0;
    for (int i = 0; i < S_DATA_COUNT; i++)
      s_ready_o[i] = rst_n_i && (int'(s_dest_i[i]) >= M_DATA_COUNT);
    for (int j = 0; j < M_DATA_COUNT; j++)
      if (busy[j] && slice_rdy[j]) s_ready_o[grant[j]] = 1'b1;
  end

  for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
    xbar_state_e             state_q, state_d;
    logic [IW-1:0]           grant_q, grant_d, last_q, last_d, arb_grant;
    logic [S_DATA_COUNT-1:0] req;
    logic                    arb_any, sel_valid, sel_last;
    logic [W-1:0]            sel_data;
    logic [IW-1:0]           sel_id;

    always_comb begin
      req = '0;
      for (int i = 0; i < S_DATA_COUNT; i++)
        req[i] = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(j)) && !held[i];
    end

    rr_arbiter #(.N(S_DATA_COUNT)) u_arb (
      .req_i       (req),
      .last_grant_i(last_q),
      .grant_o     (arb_grant),
      .any_o       (arb_any)
    );

    assign sel_valid = (state_q == ST_BUSY) && s_valid_i[grant_q];
    assign sel_last  = (state_q == ST_BUSY) && s_last_i[grant_q];
    assign sel_data  = (state_q == ST_BUSY) ? s_data_i[grant_q] : '0;
    assign sel_id    = (state_q == ST_BUSY) ? grant_q : '0;

    always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
        ST_IDLE: if (arb_any) begin
          state_d = ST_BUSY;
          grant_d = arb_grant;
        end
        ST_BUSY: if (sel_valid && slice_rdy[j] && sel_last) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q <= ST_IDLE;
        grant_q <= '0;
        last_q  <= IW'(S_DATA_COUNT - 1);
      end else begin
        state_q <= state_d;
        grant_q <= grant_d;
        last_q  <= last_d;
      end
    end

    assign busy[j]  = (state_q == ST_BUSY);
    assign grant[j] = grant_q;

`ifdef STREAM_XBAR_OUT_REG_EN
    logic          vld_q, vld_d, lst_q, lst_d;
    logic [W-1:0]  dat_q, dat_d;
    logic [IW-1:0] id_q, id_d;

    assign slice_rdy[j] = !vld_q || m_ready_i[j];

    always_comb begin
      vld_d = vld_q;
      lst_d = lst_q;
      dat_d = dat_q;
      id_d  = id_q;
      if (slice_rdy[j]) begin
        vld_d = sel_valid;
        lst_d = sel_last;
        dat_d = sel_data;
        id_d  = sel_id;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= 1'b0;
        lst_q <= 1'b0;
        dat_q <= '0;
        id_q  <= '0;
      end else begin
        vld_q <= vld_d;
        lst_q <= lst_d;
        dat_q <= dat_d;
        id_q  <= id_d;
      end
    end

    assign m_valid_o[j] = vld_q;
    assign m_last_o[j]  = lst_q;
    assign m_data_o[j]  = dat_q;
    assign m_id_o[j]    = id_q;
`else
    assign slice_rdy[j] = m_ready_i[j];
    assign m_valid_o[j] = sel_valid;
    assign m_last_o[j]  = sel_last;
    assign m_data_o[j]  = sel_data;
    assign m_id_o[j]    = sel_id;
`endif
  end

endmodule

// File: tb/tb_stream_xbar_rr.sv
// Directed scoreboard bench for stream_xbar_rr (default and STREAM_XBAR_OUT_REG_EN builds).
module tb_stream_xbar_rr;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int M  = 3;
  localparam int IW = 1;
  localparam int DW = 2;
`ifdef STREAM_XBAR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [W-1:0]  d;
    logic [DW-1:0] dest;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [S-1:0][W-1:0]  s_data_i;
  logic [S-1:0][DW-1:0] s_dest_i;
  logic [S-1:0]         s_last_i, s_valid_i, s_ready_o;
  logic [M-1:0][W-1:0]  m_data_o;
  logic [M-1:0][IW-1:0] m_id_o;
  logic [M-1:0]         m_last_o, m_valid_o, m_ready_i;

  int total = 0;
  int bad   = 0;
  beat_t          srcq [S][$];
  logic [W+IW:0]  expq [M][$];
  logic [S-1:0]   fire;

  always #5 clk = ~clk;

  stream_xbar_rr #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_data_i(s_data_i), .s_dest_i(s_dest_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int dest, input logic [W-1:0] base,
                          input logic [W-1:0] stride, input int n, input bit to_out);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.d    = base + W'(k) * stride;
      b.dest = DW'(dest);
      b.last = (k == n - 1);
      srcq[src].push_back(b);
      if (to_out) expq[dest].push_back({b.d, IW'(src), b.last});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      if (srcq[i].size() > 0) begin
        beat_t b;
        b = srcq[i][0];
        s_valid_i[i] = 1'b1;
        s_data_i[i]  = b.d;
        s_dest_i[i]  = b.dest;
        s_last_i[i]  = b.last;
      end else begin
        s_valid_i[i] = 1'b0;
        s_data_i[i]  = '0;
        s_dest_i[i]  = '0;
        s_last_i[i]  = 1'b0;
      end
    end
  endtask

  // Observe mid-cycle: scoreboard every output handshake, note input handshakes.
  task automatic sample();
    logic [W+IW:0] got, e;
    @(negedge clk);
    fire = s_valid_i & s_ready_o;
    if (rst_n) begin
      for (int j = 0; j < M; j++) begin
        if (m_valid_o[j] && m_ready_i[j]) begin
          got = {m_data_o[j], m_id_o[j], m_last_o[j]};
          total++;
          assert (expq[j].size() != 0) else begin
            bad++;
            $error("FAIL unexpected_beat out=%0d got=%0h exp=none", j, got);
          end
          if (expq[j].size() != 0) begin
            e = expq[j].pop_front();
            chk($sformatf("beat_out%0d", j), 32'(got), 32'(e));
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++)
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((srcq[0].size() + srcq[1].size() + expq[0].size() + expq[1].size()
            + expq[2].size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    m_ready_i = '1;
    fire      = '0;
    drive();

    // Reset state
    #12;
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_last",  32'(m_last_o),  32'd0);
    chk("rst_data",  32'(m_data_o),  32'd0);
    chk("rst_id",    32'(m_id_o),    32'd0);
    chk("rst_ready", 32'(s_ready_o), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet input 0 -> output 2, cycle-exact
    push_pkt(0, 2, 8'h11, 8'h11, 3, 1'b1);
    drive();
    for (int c = 0; c < LAT + 5; c++) begin
      sample();
      chk("p3_valid", 32'(m_valid_o[2]), 32'(c >= LAT && c < LAT + 3));
      chk("p3_other", 32'(m_valid_o[1:0]), 32'd0);
      if (c >= LAT && c < LAT + 3) begin
        chk("p3_data", 32'(m_data_o[2]), 32'h11 * 32'(c - LAT + 1));
        chk("p3_id",   32'(m_id_o[2]), 32'd0);
        chk("p3_last", 32'(m_last_o[2]), 32'(c == LAT + 2));
      end
      advance();
    end

    // Single-beat packet: one valid cycle only
    push_pkt(0, 2, 8'h44, 8'h00, 1, 1'b1);
    drive();
    for (int c = 0; c < LAT + 2; c++) begin
      sample();
      chk("single_valid", 32'(m_valid_o[2]), 32'(c == LAT));
      advance();
    end

    // Two inputs contend for output 0: packets alternate 0,1,0,1
    push_pkt(0, 0, 8'h01, 8'h01, 2, 1'b1);
    push_pkt(1, 0, 8'h81, 8'h01, 2, 1'b1);
    push_pkt(0, 0, 8'h03, 8'h01, 2, 1'b1);
    push_pkt(1, 0, 8'h83, 8'h01, 2, 1'b1);
    drive();
    drain("rr_alt", 100);

    // Disjoint outputs run concurrently
    push_pkt(0, 0, 8'hC0, 8'h01, 3, 1'b1);
    push_pkt(1, 2, 8'hD0, 8'h01, 3, 1'b1);
    drive();
    for (int c = 0; c <= LAT; c++) begin
      sample();
      if (c == LAT) begin
        chk("conc_v0", 32'(m_valid_o[0]), 32'd1);
        chk("conc_v2", 32'(m_valid_o[2]), 32'd1);
      end
      advance();
    end
    drain("conc", 50);

    // Back-pressure on output 1 for 4 cycles mid-packet
    push_pkt(0, 1, 8'h51, 8'h01, 6, 1'b1);
    drive();
    repeat (LAT + 2) step();
    m_ready_i[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("stall_valid", 32'(m_valid_o[1]), 32'd1);
      chk("stall_data",  32'(m_data_o[1]), 32'h53);
      chk("stall_sready", 32'(s_ready_o[0]), 32'd0);
      advance();
    end
    m_ready_i[1] = 1'b1;
    drain("stall", 50);

    // Out-of-range destination is swallowed
    push_pkt(1, 3, 8'hEE, 8'h01, 2, 1'b0);
    drive();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("drop_mvalid", 32'(m_valid_o), 32'd0);
      if (c < 2) chk("drop_sready", 32'(s_ready_o[1]), 32'd1);
      advance();
    end
    chk("drop_consumed", 32'(srcq[1].size()), 32'd0);

    // Asynchronous reset in the middle of a packet from input 1
    push_pkt(1, 1, 8'h61, 8'h01, 4, 1'b1);
    drive();
    repeat (LAT + 2) step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid_o), 32'd0);
    chk("arst_data",  32'(m_data_o),  32'd0);
    chk("arst_sready", 32'(s_ready_o), 32'd0);
    srcq[1].delete();
    expq[1].delete();
    drive();
    #7 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_pkt(0, 1, 8'h71, 8'h01, 2, 1'b1);
    push_pkt(1, 1, 8'h91, 8'h01, 1, 1'b1);
    drive();
    drain("post_rst", 50);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_xbar_rr.md
STREAM_XBAR_RR -- requirements
Module: stream_xbar_rr

Interface
- REQ-001 Parameter T_DATA_WIDTH, default 8: width of the data bus of every stream.
- REQ-002 Parameter S_DATA_COUNT, default 2: number of input (master-side) streams, at least 2.
- REQ-003 Parameter M_DATA_COUNT, default 3: number of output (slave-side) streams, at least 2.
- REQ-004 Localparam T_ID___WIDTH = $clog2(S_DATA_COUNT); localparam T_DEST_WIDTH = $clog2(M_DATA_COUNT).
- REQ-005 clk_i  in  1  single clock; every flop is rising-edge.
- REQ-006 rst_n_i  in  1  reset, asynchronous assert, active-low.
- REQ-007 s_data_i  in  T_DATA_WIDTH x S_DATA_COUNT  input data per stream.
- REQ-008 s_dest_i  in  T_DEST_WIDTH x S_DATA_COUNT  target output index per stream.
- REQ-009 s_last_i  in  S_DATA_COUNT  last beat of packet.
- REQ-010 s_valid_i  in  S_DATA_COUNT  input beat valid.
- REQ-011 s_ready_o  out  S_DATA_COUNT  input beat accepted when high together with valid.
- REQ-012 m_data_o  out  T_DATA_WIDTH x M_DATA_COUNT  output data.
- REQ-013 m_id_o  out  T_ID___WIDTH x M_DATA_COUNT  index of the source input.
- REQ-014 m_last_o  out  M_DATA_COUNT; m_valid_o  out  M_DATA_COUNT; m_ready_i  in  M_DATA_COUNT.

Function
- REQ-015 A beat transfers on any port only in a cycle where valid and ready are both high; a valid beat holds data, dest and last stable until it transfers.
- REQ-016 Input i requests output j when s_valid_i[i]=1 and s_dest_i[i]=j; each output has its own state machine with two states, IDLE and BUSY.
- REQ-017 IDLE: if the output has any requester, it grants the first requester found searching round-robin from last_grant+1 (with wrap), registers the grant, and enters BUSY on the next edge; in IDLE no data passes and m_valid_o[j]=0.
- REQ-018 BUSY: m_data_o/m_last_o/m_valid_o[j] mirror the granted input; m_id_o[j] equals the grant index; s_ready_o[grant] equals m_ready_i[j].
- REQ-019 The grant stays locked until the beat with s_last_i=1 transfers; on that edge the output enters IDLE and last_grant takes the value of the grant.
- REQ-020 An input that is not granted by any output has s_ready_o=0.
- REQ-021 An input with s_dest_i >= M_DATA_COUNT has s_ready_o=1 and its beats are discarded; the beats appear on no output.
- REQ-022 Two outputs never grant the same input; different outputs serve disjoint inputs concurrently and independently.
- REQ-023 Latency without the output register: the first beat appears on the output 1 cycle after a request in IDLE; each later beat of the packet appears in the same cycle it is presented; every packet costs one bubble cycle.
- REQ-024 A single-beat packet (last on the first beat) is legal and follows the same rules, giving IDLE, BUSY, IDLE.

Reset
- REQ-025 While rst_n_i=0: all outputs are in IDLE; m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=0, s_ready_o=0; last_grant=S_DATA_COUNT-1, so input 0 wins first.
- REQ-026 A reset during a packet truncates the packet without emitting any further beat; upstream recovery is outside this block.

Configuration
- REQ-027 With macro STREAM_XBAR_OUT_REG_EN defined, each output has a registered slice: flops for data/id/last/valid, slice ready = !valid || m_ready_i, one extra cycle of latency, full throughput, outputs driven only from flops.
- REQ-028 Without STREAM_XBAR_OUT_REG_EN, the output path is combinational as in REQ-018 and REQ-023.

Structure
- REQ-029 Package stream_xbar_pkg holds the state enum (IDLE, BUSY) and the helper functions for id and dest widths.
- REQ-030 Sub-module rr_arbiter (parameter N; inputs req, last_grant; output grant index and any-request flag) is instantiated once per output.

Verification
- REQ-031 Input 0 sends a 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) to dest 2 with m_ready=1 -> m_valid_o[2] from cycle 1, data 0x11/0x22/0x33 on consecutive cycles, m_id_o[2]=0, m_last_o[2] on 0x33.
- REQ-032 Inputs 0 and 1 both send continuous 2-beat packets to dest 0 -> packets alternate 0,1,0,1 and no beats from different inputs interleave inside a packet.
- REQ-033 m_ready_i[1]=0 for 4 cycles in the middle of a packet -> data is held stable, s_ready_o of the source is 0, and no beat is lost or duplicated.
- REQ-034 s_dest_i=3 with M_DATA_COUNT=3 -> s_ready_o=1 and all m_valid_o stay 0.
- REQ-035 rst_n_i pulsed low mid-packet, asynchronously -> m_valid_o=0 immediately, and after release input 0 wins first.
- REQ-036 Repeat REQ-031 with STREAM_XBAR_OUT_REG_EN defined -> the same data appears 1 cycle later, with full throughput under ready=1.
